branch_stack: RTL and testbench

Checkpoint store that sits between dispatch, branch resolution and the FreddyList free/complete-list block. It captures a free-list snapshot for every dispatched branch and keeps each snapshot current with later retirements. On a mispredict it drives `free_list_restore`/`restore_flag` into FreddyList and emits the mask of squashed checkpoints. Resolution is out of order; age is tracked with per-entry dependency masks.

---
 rtl/branch_stack_pkg.sv | 13 +
 rtl/branch_stack_br_tag_alloc.sv | 24 ++
 rtl/branch_stack.sv | 154 +++++++++++++++
 tb/tb_branch_stack.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_stack_pkg.sv
// Shared sizes and helpers for the branch checkpoint stack.
package branch_stack_pkg;

    localparam int unsigned BRANCH_STACK_SZ  = 4;
    localparam int unsigned PHYS_REG_SZ_R10K = 64;
    localparam int unsigned N_RETIRE         = 3;

    // Index width for a table of v entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/branch_stack_br_tag_alloc.sv
// Lowest-index free checkpoint finder.
module branch_stack_br_tag_alloc
    import branch_stack_pkg::*;
#(
    parameter  int unsigned DEPTH = BRANCH_STACK_SZ,
    localparam int unsigned TAG_W = idx_w(DEPTH)
) (
    input  logic [DEPTH-1:0] free_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             any_free_o
);

    // Scan from the top down so the lowest free index wins.
    always_comb begin
        tag_o      = '0;
        any_free_o = |free_i;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                tag_o = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// Branch checkpoint stack: free-list snapshots per in-flight branch,
// kept current with retirement, restored and squashed on mispredict.
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter  int unsigned DEPTH           = BRANCH_STACK_SZ,
    parameter  int unsigned PREGS           = PHYS_REG_SZ_R10K,
    parameter  int unsigned N               = N_RETIRE,
    localparam int unsigned BR_TAG          = idx_w(DEPTH),
    localparam int unsigned PHYS_REG_IDX    = idx_w(PREGS),
    localparam int unsigned NUM_SCALAR_BITS = idx_w(N + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 dispatch_branch_valid,
    input  logic [PREGS-1:0]                     dispatch_free_list,
    output logic [BR_TAG-1:0]                    branch_tag,
    output logic [DEPTH-1:0]                     branch_mask,
    output logic                                 stack_full,
    input  logic                                 resolve_valid,
    input  logic [BR_TAG-1:0]                    resolve_tag,
    input  logic                                 resolve_mispredict,
    input  logic [N-1:0][PHYS_REG_IDX-1:0]       phys_reg_retiring,
    input  logic [NUM_SCALAR_BITS-1:0]           num_retiring_valid,
    output logic [PREGS-1:0]                     free_list_restore,
    output logic                                 restore_flag,
    output logic [DEPTH-1:0]                     squash_mask
);

    typedef struct packed {
        logic             valid;
        logic [PREGS-1:0] snap;
        logic [DEPTH-1:0] dep;
    } checkpoint_t;

    checkpoint_t [DEPTH-1:0] stack_q, stack_d;

    logic [DEPTH-1:0]  valid_q;
    logic [PREGS-1:0]  retire_vec;
    logic [BR_TAG-1:0] alloc_tag;
    logic              any_free;
    logic              res_hit;
    logic              mispredict;
    logic              correct;
    logic              push_ok;
    logic [DEPTH-1:0]  res_onehot;

    // Flatten registered valid bits.
    always_comb begin
        valid_q = '0;
        for (int e = 0; e < DEPTH; e++) begin
            valid_q[e] = stack_q[e].valid;
        end
    end

    branch_stack_br_tag_alloc #(
        .DEPTH (DEPTH)
    ) u_tag_alloc (
        .free_i     (~valid_q),
        .tag_o      (alloc_tag),
        .any_free_o (any_free)
    );

    // Registers freed this cycle, as a one-hot-per-entry free-list mask.
    always_comb begin
        retire_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (NUM_SCALAR_BITS'(i) < num_retiring_valid) begin
                retire_vec[phys_reg_retiring[i]] = 1'b1;
            end
        end
    end

    // Resolve qualification; resolving an invalid tag is a no-op.
    always_comb begin
        res_hit    = resolve_valid & valid_q[resolve_tag];
        mispredict = res_hit & resolve_mispredict;
        correct    = res_hit & ~resolve_mispredict;
        // A mispredict squashes the dispatching (younger) branch as well.
        push_ok    = dispatch_branch_valid & any_free & ~mispredict;
        res_onehot = '0;
        if (res_hit) begin
            res_onehot[resolve_tag] = 1'b1;
        end
    end

    // Same-cycle restore toward the free list and squash mask.
    always_comb begin
        restore_flag      = mispredict;
        free_list_restore = '0;
        squash_mask       = '0;
        if (mispredict) begin
            free_list_restore = stack_q[resolve_tag].snap | retire_vec;
            for (int e = 0; e < DEPTH; e++) begin
                squash_mask[e] = valid_q[e] &
                                 ((BR_TAG'(e) == resolve_tag) | stack_q[e].dep[resolve_tag]);
            end
        end
    end

    // Next checkpoint state: fold retirement, apply resolve, allocate.
    always_comb begin
        stack_d = stack_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (stack_q[e].valid) begin
                stack_d[e].snap = stack_q[e].snap | retire_vec;
            end
            if (correct) begin
                stack_d[e].dep[resolve_tag] = 1'b0;
                if (BR_TAG'(e) == resolve_tag) begin
                    stack_d[e].valid = 1'b0;
                end
            end
            if (squash_mask[e]) begin
                stack_d[e].valid = 1'b0;
            end
        end
        // alloc_tag is invalid in stack_q, so it never collides with a resolve.
        if (push_ok) begin
            stack_d[alloc_tag].valid = 1'b1;
            stack_d[alloc_tag].snap  = dispatch_free_list | retire_vec;
            stack_d[alloc_tag].dep   = valid_q & ~res_onehot;
        end
    end

    // Checkpoint storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stack_q <= '0;
        end else begin
            stack_q <= stack_d;
        end
    end

    // Status derived only from registered valid.
    always_comb begin
        branch_tag  = alloc_tag;
        branch_mask = valid_q;
        stack_full  = &valid_q;
    end

    // Resolve must target a live checkpoint.
    a_resolve_valid_tag: assert property (
        @(posedge clock) disable iff (!reset)
        resolve_valid |-> valid_q[resolve_tag]
    );

    // Dispatch must stall while the stack is full.
    a_no_push_when_full: assert property (
        @(posedge clock) disable iff (!reset)
        dispatch_branch_valid |-> !stack_full
    );

endmodule

// File: tb/tb_branch_stack.sv
// Directed bench for branch_stack (DEPTH=4, PREGS=64, N=3).
module tb_branch_stack;

    logic             clk;
    logic             rst_n;
    logic             dispatch_branch_valid;
    logic [63:0]      dispatch_free_list;
    logic [1:0]       branch_tag;
    logic [3:0]       branch_mask;
    logic             stack_full;
    logic             resolve_valid;
    logic [1:0]       resolve_tag;
    logic             resolve_mispredict;
    logic [2:0][5:0]  phys_reg_retiring;
    logic [1:0]       num_retiring_valid;
    logic [63:0]      free_list_restore;
    logic             restore_flag;
    logic [3:0]       squash_mask;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] FL_A = 64'h0000_0000_0000_1111;
    localparam logic [63:0] FL_B = 64'h0000_0000_2222_0000;
    localparam logic [63:0] FL_C = 64'h0000_3333_0000_0000;
    localparam logic [63:0] FL_D = 64'h4444_0000_0000_0000;

    branch_stack #(
        .DEPTH (4),
        .PREGS (64),
        .N     (3)
    ) dut (
        .clock                 (clk),
        .reset                 (rst_n),
        .dispatch_branch_valid (dispatch_branch_valid),
        .dispatch_free_list    (dispatch_free_list),
        .branch_tag            (branch_tag),
        .branch_mask           (branch_mask),
        .stack_full            (stack_full),
        .resolve_valid         (resolve_valid),
        .resolve_tag           (resolve_tag),
        .resolve_mispredict    (resolve_mispredict),
        .phys_reg_retiring     (phys_reg_retiring),
        .num_retiring_valid    (num_retiring_valid),
        .free_list_restore     (free_list_restore),
        .restore_flag          (restore_flag),
        .squash_mask           (squash_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_branch_valid = 1'b0;
        dispatch_free_list    = '0;
        resolve_valid         = 1'b0;
        resolve_tag           = '0;
        resolve_mispredict    = 1'b0;
        phys_reg_retiring     = '0;
        num_retiring_valid    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [63:0] fl, input logic [1:0] exp_tag);
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = fl;
        #1;
        check("push_tag", 64'(branch_tag), 64'(exp_tag));
        cycle();
        dispatch_branch_valid = 1'b0;
        dispatch_free_list    = '0;
    endtask

    task automatic resolve(input logic [1:0] tag, input logic mp);
        resolve_valid      = 1'b1;
        resolve_tag        = tag;
        resolve_mispredict = mp;
        #1;
    endtask

    task automatic end_resolve();
        cycle();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
        resolve_tag        = '0;
        #1;
    endtask

    task automatic fill4();
        push(FL_A, 2'd0);
        push(FL_B, 2'd1);
        push(FL_C, 2'd2);
        push(FL_D, 2'd3);
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;

        // Reset state.
        do_reset();
        #1;
        check("rst_mask", 64'(branch_mask), 64'h0);
        check("rst_full", 64'(stack_full), 64'h0);
        check("rst_tag", 64'(branch_tag), 64'h0);
        check("rst_restore", 64'(restore_flag), 64'h0);
        check("rst_squash", 64'(squash_mask), 64'h0);
        check("rst_flr", free_list_restore, 64'h0);

        // 1: fill, then correct-resolve the oldest.
        fill4();
        #1;
        check("t1_full", 64'(stack_full), 64'h1);
        check("t1_mask", 64'(branch_mask), 64'hF);
        resolve(2'd0, 1'b0);
        check("t1_corr_flag", 64'(restore_flag), 64'h0);
        check("t1_corr_squash", 64'(squash_mask), 64'h0);
        check("t1_corr_flr", free_list_restore, 64'h0);
        end_resolve();
        check("t1_notfull", 64'(stack_full), 64'h0);
        check("t1_mask2", 64'(branch_mask), 64'hE);
        push(FL_A, 2'd0);

        // 2: mispredict with younger entries.
        do_reset();
        fill4();
        resolve(2'd1, 1'b1);
        check("t2_flag", 64'(restore_flag), 64'h1);
        check("t2_flr", free_list_restore, FL_B);
        check("t2_squash", 64'(squash_mask), 64'hE);
        end_resolve();
        check("t2_mask", 64'(branch_mask), 64'h1);
        push(FL_C, 2'd1);

        // 3: retirement folding into a snapshot, plus same-cycle retire.
        do_reset();
        push(64'h0, 2'd0);
        phys_reg_retiring  = {6'd12, 6'd9, 6'd5};
        num_retiring_valid = 2'd3;
        cycle();
        num_retiring_valid = 2'd0;
        resolve(2'd0, 1'b1);
        check("t3_flr", free_list_restore, 64'h0000_0000_0000_1220);
        check("t3_squash", 64'(squash_mask), 64'h1);
        #1;
        phys_reg_retiring  = {6'd40, 6'd30, 6'd20};
        num_retiring_valid = 2'd2;
        #1;
        check("t3_flr_same", free_list_restore, 64'h0000_0000_4010_1220);
        end_resolve();
        num_retiring_valid = 2'd0;
        check("t3_mask", 64'(branch_mask), 64'h0);

        // 4a: push + mispredict drops the push.
        do_reset();
        push(FL_A, 2'd0);
        dispatch_branch_valid = 1'b1;
        dispatch_free_list    = FL_B;
        resolve(2'd0, 1'b1);
        check("t4a_flr", free_list_restore, FL_A);
        check("t4a_squash", 64'(squash_mask), 64'h1);
        dispatch_branch_valid = 1'b0;
        #1;
        end_resolve();
        check("t4a_mask", 64'(branch_mask), 64'h0);

        // 4b: push + correct resolve; new entry must not depend on tag 0.
        do_reset();
        push(FL_A, 2'd0);
        push(FL_B, 2'd1);
        resolve(2'd0, 1'b0);
        push(FL_C, 2'd2);
        resolve_valid = 1'b0;
        #1;
        check("t4b_mask", 64'(branch_mask), 64'h6);
        push(FL_D, 2'd0);
        resolve(2'd0, 1'b1);
        check("t4b_young_squash", 64'(squash_mask), 64'h1);
        check("t4b_young_flr", free_list_restore, FL_D);
        end_resolve();
        check("t4b_mask2", 64'(branch_mask), 64'h6);
        resolve(2'd1, 1'b1);
        check("t4b_squash", 64'(squash_mask), 64'h6);
        check("t4b_flr", free_list_restore, FL_B);
        end_resolve();
        check("t4b_mask3", 64'(branch_mask), 64'h0);

        // 5: out-of-order correct resolve, then mispredict oldest.
        do_reset();
        fill4();
        resolve(2'd2, 1'b0);
        end_resolve();
        check("t5_mask", 64'(branch_mask), 64'hB);
        resolve(2'd0, 1'b1);
        check("t5_squash", 64'(squash_mask), 64'hB);
        check("t5_flr", free_list_restore, FL_A);
        end_resolve();
        check("t5_mask2", 64'(branch_mask), 64'h0);

        // 6: asynchronous reset in the middle of a restore.
        do_reset();
        push(FL_A, 2'd0);
        push(FL_B, 2'd1);
        resolve(2'd0, 1'b1);
        check("t6_pre_flag", 64'(restore_flag), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t6_flag", 64'(restore_flag), 64'h0);
        check("t6_flr", free_list_restore, 64'h0);
        check("t6_squash", 64'(squash_mask), 64'h0);
        check("t6_mask", 64'(branch_mask), 64'h0);
        check("t6_full", 64'(stack_full), 64'h0);
        check("t6_tag", 64'(branch_tag), 64'h0);
        idle_inputs();
        cycle();
        rst_n = 1'b1;
        push(FL_C, 2'd0);
        check("t6_mask_after", 64'(branch_mask), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
